inst_cache_refill: RTL and testbench
====================================

Name: inst_cache_refill

Overview:
- Fill/maintenance side of the instruction cache tag/valid array. On a lookup miss it fetches the missing line with one AXI4 INCR read burst, writes the data RAM word by word, then writes tag+valid.
- Also performs CACHE-op invalidates (valid=0 writes) and an optional next-line prefetch when the lookup reports the next line absent.
- Sits between the I-cache lookup stage and the AXI read arbiter.

Parameters:
- INDEX_WIDTH, 7, cache set index bits.
- TAG_WIDTH, 20, tag bits (32 - INDEX_WIDTH - OFFSET_WIDTH).
- OFFSET_WIDTH, 5, byte offset bits in a line (32-byte line).
- WORDS, 8, 32-bit words per line (2^(OFFSET_WIDTH-2)).
- AXI_ID, 4'd0, ARID driven on every burst.
- PREFETCH_EN, 1, enables next-line prefetch.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- miss_req  in  1  level; lookup missed, held until refill_done
- miss_addr  in  32  missing fetch address, stable while miss_req
- pre_found  in  1  next line already valid; sampled at refill end
- op_req  in  1  invalidate request (single-cycle pulse)
- op_index  in  INDEX_WIDTH  set to invalidate
- op_ack  out  1  pulse; invalidate written
- refill_done  out  1  pulse; demand line written
- refill_err  out  1  pulse with refill_done when any RRESP != OKAY
- resp_word  out  32  word at miss_addr offset, valid with refill_done
- busy  out  1  FSM not in IDLE
- tagv_wen  out  1  tag/valid write strobe
- tagv_index  out  INDEX_WIDTH  tag/valid write set
- tagv_tag  out  TAG_WIDTH  tag write data
- tagv_valid  out  1  valid write data
- data_wen  out  1  data RAM word write strobe
- data_index  out  INDEX_WIDTH  data RAM write set
- data_offset  out  OFFSET_WIDTH-2  word within the line
- data_wdata  out  32  data RAM write word
- arid, araddr, arlen, arsize, arburst, arvalid  out  4/32/8/3/2/1  AXI AR channel
- arready  in  1  AXI AR channel
- rdata, rresp, rlast, rvalid  in  32/2/1/1  AXI R channel
- rready  out  1  AXI R channel

Behaviour:
- Reset: FSM enters IDLE. All strobes and outputs are 0: arvalid, rready, tagv_wen, data_wen, refill_done, refill_err, op_ack, busy. Beat counter is 0.
- States: IDLE, AR, R, TAGW, DONE.
- IDLE priority:
  - op_req wins over miss_req. Issue a one-cycle write with tagv_wen=1, tagv_valid=0, tagv_tag=0, index=op_index. op_ack pulses the same cycle. Stay in IDLE.
  - Otherwise, on miss_req, latch line base = {miss_addr[31:OFFSET_WIDTH], 0} and the word offset. Set kind=demand and go to AR.
- AR:
  - arvalid=1, araddr=line base, arlen=WORDS-1, arsize=3'b010, arburst=2'b01, arid=AXI_ID.
  - AR fields are constant while arvalid is high. arvalid drops after the arready handshake. Go to R.
- R:
  - rready=1.
  - Each rvalid beat: data_wen=1 same cycle, data_offset=beat counter, data_wdata=rdata; counter increments.
  - OR rresp!=0 into an error flag.
  - If the beat equals the latched offset, capture it as resp_word (demand only).
  - On the rlast beat go to TAGW. Bursts are trusted: rlast arrives on beat WORDS-1; the counter wraps at WORDS.
- TAGW:
  - One cycle with tagv_wen=1, tag and index from the latched line, tagv_valid = !error_flag.
  - Demand: go to DONE. Prefetch: go to IDLE.
- DONE:
  - One cycle with refill_done=1 and refill_err=error_flag.
  - If PREFETCH_EN, !pre_found and !error_flag: line base += 2^OFFSET_WIDTH (32-bit wrap; tag carries on index wrap). Set kind=prefetch and go to AR.
  - Otherwise go to IDLE.
- During a prefetch:
  - miss_req and op_req are not serviced until IDLE. op_req is lost unless the source holds it, so the source must hold op_req while busy.
  - refill_done is never pulsed for a prefetch line.
- Data writes never overlap tagv writes. The line's valid bit is written only after all data beats land, so there is no partially valid line.
- busy=1 in every state except IDLE.
- Reset mid-burst returns to IDLE immediately. The interconnect shares resetn, so no burst drain is required.

Decomposition:
- Shared package/include (the Cache.vh defines):
  - INST_CACHE_INDEX_WIDTH, INST_CACHE_TAG_WIDTH, OFFSET_WIDTH, WORDS
  - FSM state encodings
  - AXI constants: BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00
- No sub-module. The single FSM with datapath latches fits within ~200 lines.

Test Plan:
- Demand miss at 0x1FC0_0024, arready after 2 cycles, 8 beats rdata=0xA0+i, rresp=0 -> araddr=0x1FC0_0020, arlen=7; data_wen at offsets 0..7; tagv write index=0x01, tag=0x1FC00, valid=1; refill_done with resp_word=0xA1.
- Same miss with pre_found=0 -> second AR araddr=0x1FC0_0040; tagv index=0x02 valid=1; no second refill_done.
- Miss at 0x0000_0FE0 (index 0x7F), pre_found=0 -> prefetch araddr=0x0000_1000, tagv index=0x00, tag=0x00001.
- Beat 3 with rresp=2'b10 -> all 8 data writes occur; tagv_valid=0; refill_done and refill_err=1; no prefetch.
- op_req index=0x15 and miss_req in the same cycle -> tagv_wen index=0x15 valid=0 and op_ack first; AR issued next cycle.
- resetn low mid-R (beat 4) -> arvalid, rready, busy and strobes 0 asynchronously; after release a new miss restarts at beat 0.

Source files
------------

// File: rtl/inst_cache_refill_pkg.sv
// Shared geometry, FSM encodings and AXI constants for the I-cache refill engine.
package inst_cache_refill_pkg;

    localparam int INST_CACHE_INDEX_WIDTH  = 7;
    localparam int INST_CACHE_TAG_WIDTH    = 20;
    localparam int INST_CACHE_OFFSET_WIDTH = 5;
    localparam int INST_CACHE_WORDS        = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_TAGW = 3'd3,
        S_DONE = 3'd4
    } state_t;

    typedef enum logic {
        K_DEMAND   = 1'b0,
        K_PREFETCH = 1'b1
    } kind_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/inst_cache_refill.sv
// I-cache line refill / invalidate engine: one AXI INCR burst per line, data
// words written as they arrive, tag+valid written last, optional next-line prefetch.
module inst_cache_refill
    import inst_cache_refill_pkg::*;
#(
    parameter int         INDEX_WIDTH  = INST_CACHE_INDEX_WIDTH,
    parameter int         TAG_WIDTH    = INST_CACHE_TAG_WIDTH,
    parameter int         OFFSET_WIDTH = INST_CACHE_OFFSET_WIDTH,
    parameter int         WORDS        = INST_CACHE_WORDS,
    parameter logic [3:0] AXI_ID       = 4'd0,
    parameter bit         PREFETCH_EN  = 1'b1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    miss_req,
    input  logic [31:0]             miss_addr,
    input  logic                    pre_found,
    input  logic                    op_req,
    input  logic [INDEX_WIDTH-1:0]  op_index,
    output logic                    op_ack,
    output logic                    refill_done,
    output logic                    refill_err,
    output logic [31:0]             resp_word,
    output logic                    busy,
    output logic                    tagv_wen,
    output logic [INDEX_WIDTH-1:0]  tagv_index,
    output logic [TAG_WIDTH-1:0]    tagv_tag,
    output logic                    tagv_valid,
    output logic                    data_wen,
    output logic [INDEX_WIDTH-1:0]  data_index,
    output logic [OFFSET_WIDTH-3:0] data_offset,
    output logic [31:0]             data_wdata,
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int LINE_W = TAG_WIDTH + INDEX_WIDTH;
    localparam int WORD_W = OFFSET_WIDTH - 2;

    state_t                  r_state;
    kind_t                   r_kind;
    logic [LINE_W-1:0]       r_line;
    logic [WORD_W-1:0]       r_word_off;
    logic [WORD_W-1:0]       r_beat;
    logic                    r_err;
    logic                    r_arvalid;
    logic                    r_rready;
    logic                    r_tagv_wen;
    logic [INDEX_WIDTH-1:0]  r_tagv_index;
    logic [TAG_WIDTH-1:0]    r_tagv_tag;
    logic                    r_tagv_valid;
    logic                    r_op_ack;
    logic                    r_refill_done;
    logic                    r_refill_err;
    logic [31:0]             r_resp_word;

    logic w_beat;
    logic w_beat_err;
    logic w_unused;

    assign w_beat     = r_rready & rvalid;
    assign w_beat_err = (rresp != RESP_OKAY);
    // Byte-within-word bits never matter for a line fetch.
    assign w_unused   = ^miss_addr[1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_kind        <= K_DEMAND;
            r_line        <= '0;
            r_word_off    <= '0;
            r_beat        <= '0;
            r_err         <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_tagv_wen    <= 1'b0;
            r_tagv_index  <= '0;
            r_tagv_tag    <= '0;
            r_tagv_valid  <= 1'b0;
            r_op_ack      <= 1'b0;
            r_refill_done <= 1'b0;
            r_refill_err  <= 1'b0;
            r_resp_word   <= '0;
        end else begin
            r_tagv_wen    <= 1'b0;
            r_op_ack      <= 1'b0;
            r_refill_done <= 1'b0;
            r_refill_err  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (op_req) begin
                        r_tagv_wen   <= 1'b1;
                        r_tagv_index <= op_index;
                        r_tagv_tag   <= '0;
                        r_tagv_valid <= 1'b0;
                        r_op_ack     <= 1'b1;
                    end else if (miss_req) begin
                        r_line     <= miss_addr[31:OFFSET_WIDTH];
                        r_word_off <= miss_addr[OFFSET_WIDTH-1:2];
                        r_kind     <= K_DEMAND;
                        r_err      <= 1'b0;
                        r_beat     <= '0;
                        r_arvalid  <= 1'b1;
                        r_state    <= S_AR;
                    end
                end

                S_AR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_R;
                    end
                end

                S_R: begin
                    if (w_beat) begin
                        r_beat <= r_beat + WORD_W'(1);
                        if (w_beat_err)
                            r_err <= 1'b1;
                        if (r_kind == K_DEMAND && r_beat == r_word_off)
                            r_resp_word <= rdata;
                        // Tag/valid goes out only after the last data word has landed.
                        if (rlast) begin
                            r_rready     <= 1'b0;
                            r_tagv_wen   <= 1'b1;
                            r_tagv_index <= r_line[INDEX_WIDTH-1:0];
                            r_tagv_tag   <= r_line[LINE_W-1:INDEX_WIDTH];
                            r_tagv_valid <= ~(r_err | w_beat_err);
                            r_state      <= S_TAGW;
                        end
                    end
                end

                S_TAGW: begin
                    if (r_kind == K_DEMAND) begin
                        r_refill_done <= 1'b1;
                        r_refill_err  <= r_err;
                        r_state       <= S_DONE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_DONE: begin
                    if (PREFETCH_EN && !pre_found && !r_err) begin
                        // Line increment carries from index into tag naturally.
                        r_line    <= r_line + LINE_W'(1);
                        r_kind    <= K_PREFETCH;
                        r_beat    <= '0;
                        r_arvalid <= 1'b1;
                        r_state   <= S_AR;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign op_ack      = r_op_ack;
    assign refill_done = r_refill_done;
    assign refill_err  = r_refill_err;
    assign resp_word   = r_resp_word;

    assign tagv_wen    = r_tagv_wen;
    assign tagv_index  = r_tagv_index;
    assign tagv_tag    = r_tagv_tag;
    assign tagv_valid  = r_tagv_valid;

    assign data_wen    = w_beat;
    assign data_index  = r_line[INDEX_WIDTH-1:0];
    assign data_offset = r_beat;
    assign data_wdata  = rdata;

    assign arid        = AXI_ID;
    assign araddr      = {r_line, {OFFSET_WIDTH{1'b0}}};
    assign arlen       = 8'(WORDS - 1);
    assign arsize      = SIZE_4B;
    assign arburst     = BURST_INCR;
    assign arvalid     = r_arvalid;
    assign rready      = r_rready;

endmodule

// File: tb/tb_inst_cache_refill.sv
// Directed bench for inst_cache_refill: demand refills, prefetch, index wrap,
// error response, invalidate priority and mid-burst reset.
module tb_inst_cache_refill;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        miss_req = 1'b0;
    logic [31:0] miss_addr = '0;
    logic        pre_found = 1'b1;
    logic        op_req = 1'b0;
    logic [6:0]  op_index = '0;
    logic        op_ack;
    logic        refill_done;
    logic        refill_err;
    logic [31:0] resp_word;
    logic        busy;
    logic        tagv_wen;
    logic [6:0]  tagv_index;
    logic [19:0] tagv_tag;
    logic        tagv_valid;
    logic        data_wen;
    logic [6:0]  data_index;
    logic [2:0]  data_offset;
    logic [31:0] data_wdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;

    int n_checks = 0;
    int n_fail   = 0;

    inst_cache_refill dut (
        .clk(clk), .resetn(resetn),
        .miss_req(miss_req), .miss_addr(miss_addr), .pre_found(pre_found),
        .op_req(op_req), .op_index(op_index), .op_ack(op_ack),
        .refill_done(refill_done), .refill_err(refill_err), .resp_word(resp_word),
        .busy(busy),
        .tagv_wen(tagv_wen), .tagv_index(tagv_index), .tagv_tag(tagv_tag), .tagv_valid(tagv_valid),
        .data_wen(data_wen), .data_index(data_index), .data_offset(data_offset), .data_wdata(data_wdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ar(input logic [31:0] exp_addr, input int delay);
        int n = 0;
        while (arvalid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("ar_seen", 32'(arvalid), 32'd1);
        chk("araddr", araddr, exp_addr);
        chk("arlen", 32'(arlen), 32'd7);
        chk("arsize", 32'(arsize), 32'd2);
        chk("arburst", 32'(arburst), 32'd1);
        chk("arid", 32'(arid), 32'd0);
        chk("ar_busy", 32'(busy), 32'd1);
        for (int i = 0; i < delay; i++) begin
            step();
            chk("ar_hold_valid", 32'(arvalid), 32'd1);
            chk("ar_hold_addr", araddr, exp_addr);
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("ar_drop", 32'(arvalid), 32'd0);
        chk("r_rready", 32'(rready), 32'd1);
        $display("AR   addr=0x%08h delay=%0d", exp_addr, delay);
    endtask

    task automatic do_beats(input logic [31:0] base, input int err_beat,
                            input logic [6:0] exp_index, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            rdata  = base + 32'(i);
            rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            rlast  = (i == 7);
            rvalid = 1'b1;
            #1;
            chk("data_wen", 32'(data_wen), 32'd1);
            chk("data_offset", 32'(data_offset), 32'(i));
            chk("data_wdata", data_wdata, base + 32'(i));
            chk("data_index", 32'(data_index), 32'(exp_index));
            chk("r_no_tagv", 32'(tagv_wen), 32'd0);
            step();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        #1;
        $display("R    base=0x%08h beats=%0d err_beat=%0d", base, nbeats, err_beat);
    endtask

    task automatic chk_tagw(input logic [6:0] idx, input logic [19:0] tag, input logic valid);
        chk("tagv_wen", 32'(tagv_wen), 32'd1);
        chk("tagv_index", 32'(tagv_index), 32'(idx));
        chk("tagv_tag", 32'(tagv_tag), 32'(tag));
        chk("tagv_valid", 32'(tagv_valid), 32'(valid));
        chk("tagw_no_data", 32'(data_wen), 32'd0);
        chk("tagw_no_done", 32'(refill_done), 32'd0);
        $display("TAGW index=0x%02h tag=0x%05h valid=%0d", idx, tag, valid);
    endtask

    task automatic chk_done(input logic err, input logic [31:0] word);
        chk("refill_done", 32'(refill_done), 32'd1);
        chk("refill_err", 32'(refill_err), 32'(err));
        chk("resp_word", resp_word, word);
        $display("DONE err=%0d resp_word=0x%08h", err, word);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        step();
        step();
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_tagv_wen", 32'(tagv_wen), 32'd0);
        chk("rst_data_wen", 32'(data_wen), 32'd0);
        chk("rst_refill_done", 32'(refill_done), 32'd0);
        chk("rst_refill_err", 32'(refill_err), 32'd0);
        chk("rst_op_ack", 32'(op_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        step();

        // Demand miss, next line present
        miss_addr = 32'h1FC0_0024;
        miss_req  = 1'b1;
        pre_found = 1'b1;
        step();
        do_ar(32'h1FC0_0020, 2);
        do_beats(32'hA0, -1, 7'h01, 8);
        chk_tagw(7'h01, 20'h1FC00, 1'b1);
        step();
        chk_done(1'b0, 32'hA1);
        miss_req = 1'b0;
        step();
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_done", 32'(refill_done), 32'd0);
        chk("t1_idle_ar", 32'(arvalid), 32'd0);

        // Same miss, next line absent -> prefetch of 0x1FC0_0040
        miss_req  = 1'b1;
        pre_found = 1'b0;
        step();
        do_ar(32'h1FC0_0020, 0);
        do_beats(32'hB0, -1, 7'h01, 8);
        chk_tagw(7'h01, 20'h1FC00, 1'b1);
        step();
        chk_done(1'b0, 32'hB1);
        miss_req = 1'b0;
        step();
        do_ar(32'h1FC0_0040, 1);
        do_beats(32'hC0, -1, 7'h02, 8);
        chk_tagw(7'h02, 20'h1FC00, 1'b1);
        step();
        chk("t2_idle_busy", 32'(busy), 32'd0);
        chk("t2_no_done", 32'(refill_done), 32'd0);
        chk("t2_resp_kept", resp_word, 32'hB1);

        // Index wrap: prefetch carries into the tag
        miss_addr = 32'h0000_0FE0;
        miss_req  = 1'b1;
        step();
        do_ar(32'h0000_0FE0, 0);
        do_beats(32'hD0, -1, 7'h7F, 8);
        chk_tagw(7'h7F, 20'h00000, 1'b1);
        step();
        chk_done(1'b0, 32'hD0);
        miss_req = 1'b0;
        step();
        do_ar(32'h0000_1000, 0);
        do_beats(32'hE0, -1, 7'h00, 8);
        chk_tagw(7'h00, 20'h00001, 1'b1);
        step();
        chk("t3_idle_busy", 32'(busy), 32'd0);

        // Error on beat 3: line left invalid, no prefetch
        miss_addr = 32'h2000_0008;
        miss_req  = 1'b1;
        step();
        do_ar(32'h2000_0000, 0);
        do_beats(32'hF0, 3, 7'h00, 8);
        chk_tagw(7'h00, 20'h20000, 1'b0);
        step();
        chk_done(1'b1, 32'hF2);
        miss_req = 1'b0;
        step();
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_no_prefetch", 32'(arvalid), 32'd0);
        step();
        chk("t4_no_prefetch2", 32'(arvalid), 32'd0);

        // Invalidate wins over a simultaneous miss
        pre_found = 1'b1;
        miss_addr = 32'h1FC0_0024;
        miss_req  = 1'b1;
        op_index  = 7'h15;
        op_req    = 1'b1;
        step();
        op_req = 1'b0;
        chk("op_tagv_wen", 32'(tagv_wen), 32'd1);
        chk("op_tagv_index", 32'(tagv_index), 32'h15);
        chk("op_tagv_valid", 32'(tagv_valid), 32'd0);
        chk("op_tagv_tag", 32'(tagv_tag), 32'd0);
        chk("op_ack", 32'(op_ack), 32'd1);
        chk("op_no_ar", 32'(arvalid), 32'd0);
        $display("OP   index=0x15 ack=%0d", op_ack);
        step();
        chk("op_ack_pulse", 32'(op_ack), 32'd0);
        chk("op_tagv_pulse", 32'(tagv_wen), 32'd0);
        chk("op_then_ar", 32'(arvalid), 32'd1);
        do_ar(32'h1FC0_0020, 0);

        // Reset in the middle of the burst at beat 4
        do_beats(32'h60, -1, 7'h01, 4);
        rdata  = 32'h64;
        rvalid = 1'b1;
        #1;
        chk("mid_beat4_wen", 32'(data_wen), 32'd1);
        chk("mid_beat4_off", 32'(data_offset), 32'd4);
        resetn = 1'b0;
        #1;
        chk("mid_rst_arvalid", 32'(arvalid), 32'd0);
        chk("mid_rst_rready", 32'(rready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data_wen", 32'(data_wen), 32'd0);
        chk("mid_rst_tagv_wen", 32'(tagv_wen), 32'd0);
        $display("RST  asserted mid-burst at beat 4");
        rvalid = 1'b0;
        step();
        resetn = 1'b1;
        step();
        do_ar(32'h1FC0_0020, 0);
        do_beats(32'h50, -1, 7'h01, 8);
        chk_tagw(7'h01, 20'h1FC00, 1'b1);
        step();
        chk_done(1'b0, 32'h51);
        miss_req = 1'b0;
        step();
        chk("t6_idle_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
